// File: rtl/fetch_unit.sv
// Multi-cycle instruction fetch stage: owns the PC, fetches over a ready
// handshake, holds the instruction until retirement and counts retirements.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        reset_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] instr_o,
  output logic [5:0]  op_o,
  output logic [5:0]  funct_o,
  output logic        instr_valid_o,
  input  logic        retire_i,
  input  logic        pcsrc_i,
  input  logic        jump_i,
  input  logic [31:0] signimm_i,
  output logic [31:0] pc_o,
  output logic [31:0] pcplus4_o,
  output logic [31:0] instret_o
);

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instret_q, instret_d;
  logic        imem_req_q, imem_req_d;
  logic        instr_valid_q, instr_valid_d;

  logic [31:0] pcplus4_s;
  logic [31:0] branch_tgt_s;
  logic [31:0] jump_tgt_s;
  logic [31:0] next_pc_s;

  assign pcplus4_s    = pc_q + 32'd4;
  assign branch_tgt_s = pcplus4_s + (signimm_i << 2'd2);
  assign jump_tgt_s   = {pcplus4_s[31:28], instr_q[25:0], 2'b00};

  // Next-PC select; jump wins over a taken branch.
  always_comb begin
    next_pc_s = pcplus4_s;
    if (jump_i) begin
      next_pc_s = jump_tgt_s;
    end else if (pcsrc_i) begin
      next_pc_s = branch_tgt_s;
    end else begin
      next_pc_s = pcplus4_s;
    end
  end

  // FETCH/HOLD next-state; request and valid flags are registered alongside state.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instret_d     = instret_q;
    imem_req_d    = imem_req_q;
    instr_valid_d = instr_valid_q;
    case (state_q)
      FETCH: begin
        if (imem_ready_i) begin
          instr_d       = imem_rdata_i;
          state_d       = HOLD;
          imem_req_d    = 1'b0;
          instr_valid_d = 1'b1;
        end else begin
          state_d = FETCH;
        end
      end
      HOLD: begin
        if (retire_i) begin
          pc_d          = next_pc_s;
          instret_d     = instret_q + 32'd1;
          state_d       = FETCH;
          imem_req_d    = 1'b1;
          instr_valid_d = 1'b0;
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d       = FETCH;
        imem_req_d    = 1'b1;
        instr_valid_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= FETCH;
      pc_q          <= RESET_PC;
      instr_q       <= 32'h0000_0000;
      instret_q     <= 32'h0000_0000;
      imem_req_q    <= 1'b1;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instret_q     <= instret_d;
      imem_req_q    <= imem_req_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  assign imem_req_o    = imem_req_q;
  assign imem_addr_o   = pc_q;
  assign instr_o       = instr_q;
  assign op_o          = instr_q[31:26];
  assign funct_o       = instr_q[5:0];
  assign instr_valid_o = instr_valid_q;
  assign pc_o          = pc_q;
  assign pcplus4_o     = pcplus4_s;
  assign instret_o     = instret_q;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Multi-cycle instruction fetch stage sitting directly upstream of the controller and datapath. It owns the PC, issues requests to instruction memory over a ready handshake, holds the fetched instruction stable (exposing `op`/`funct` to the controller) until downstream retires it, then selects the next PC from the controller's `jump`/`pcsrc` outputs. It also counts retired instructions.

## Interface
- `RESET_PC`, 32'h0000_0000: PC loaded on reset; must be word-aligned.
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `imem_req`  out  1  fetch request to instruction memory.
- `imem_addr`  out  32  fetch address; equals `pc`.
- `imem_ready`  in  1  memory response valid this cycle; `imem_rdata` valid when high.
- `imem_rdata`  in  32  fetched instruction word.
- `instr`  out  32  held instruction register.
- `op`  out  6  `instr[31:26]`.
- `funct`  out  6  `instr[5:0]`.
- `instr_valid`  out  1  `instr` is valid and awaiting retirement.
- `retire`  in  1  downstream completes the held instruction this cycle.
- `pcsrc`  in  1  branch taken (from controller); sampled only on retire.
- `jump`  in  1  jump (from controller); sampled only on retire.
- `signimm`  in  32  sign-extended immediate from datapath; sampled only on retire.
- `pc`  out  32  current PC.
- `pcplus4`  out  32  `pc + 4`, combinational, mod 2^32.
- `instret`  out  32  retired-instruction counter.

## Operation
- Two-state FSM: FETCH, HOLD.
- FETCH: `imem_req`=1, `imem_addr`=`pc`, `instr_valid`=0. On a cycle with `imem_ready`=1, `instr` <= `imem_rdata`, go to HOLD. Otherwise stay; `pc` and `imem_addr` remain stable.
- HOLD: `imem_req`=0, `instr_valid`=1, `instr` stable. On a cycle with `retire`=1: `pc` <= next PC, `instret` <= `instret`+1, go to FETCH. Otherwise stay.
- Next PC, evaluated in the retire cycle:
  - `jump`=1: `{pcplus4[31:28], instr[25:0], 2'b00}`.
  - else `pcsrc`=1: `pcplus4 + (signimm << 2)`, 32-bit wrap, carry discarded.
  - else: `pcplus4`.
  - `jump` has priority over `pcsrc` when both are high.
- `retire` is ignored in FETCH. `imem_ready` is ignored in HOLD, and `instr` is not overwritten.
- `op` and `funct` are pure slices of the `instr` register. They are meaningful only while `instr_valid`=1, but are always driven.
- `instret` wraps from 32'hFFFF_FFFF to 0 with no flag.
- PC arithmetic wraps at 2^32. `pc` = 32'hFFFF_FFFC gives `pcplus4` = 0.

## Timing
- Values after a reset edge: state=FETCH, `pc`=`RESET_PC`, `instr`=0, `instr_valid`=0, `instret`=0, `imem_req`=1, `imem_addr`=`RESET_PC`.
- Reset has priority over every other input in the same cycle, including `imem_ready` and `retire`.
- Reset mid-fetch or mid-hold abandons the current instruction, and `instret` is not incremented.
- Instruction memory shares `reset` and must not return a response for an abandoned request.
- Zero-wait memory (`imem_ready` in the first FETCH cycle):
  - `instr_valid` rises on the next cycle.
  - Minimum throughput is 2 cycles per instruction when `retire` is asserted in the first HOLD cycle.
- With N memory wait cycles, `instr_valid` rises N+1 cycles after FETCH entry.
- After retire, the new `pc` is visible and `imem_req`=1 on the following cycle.
- No combinational path from `imem_ready` or `retire` to any output.
- `pcplus4`, `op` and `funct` are combinational from registers only.

## Test plan
- **Reset values:** hold `reset` 2 cycles with `RESET_PC`=0. Require `imem_req`=1, `imem_addr`=0, `instr_valid`=0, `instret`=0 on the first cycle after release.
- **Zero-wait sequential fetch:** memory always ready; rdata at 0x0 = 0x2008_0005 (addi). Retire each instruction in the first HOLD cycle. Require addresses 0x0, 0x4, 0x8 on alternate cycles, `op`=6'h08 while holding the first instruction, and `instret`=3 after the third retire.
- **Wait states:** `imem_ready` delayed 3 cycles. Require `imem_addr` stable for 4 cycles and `instr_valid` rising 4 cycles after FETCH entry.
- **Taken branch:** at `pc`=0x10, retire with `pcsrc`=1 and `signimm`=32'hFFFF_FFFE. Require next `pc`=0x0C.
- **Jump priority:** at `pc`=0x0040_0000 with `instr`=0x0810_0004, retire with `jump`=1 and `pcsrc`=1. Require next `pc`=0x0040_0010.
- **Reset mid-hold and ignored inputs:**
  - In HOLD at `pc`=0x20 with `instret`=5, assert `reset` together with `retire`. Require `pc`=`RESET_PC`, `instret`=0, `instr_valid`=0.
  - Separately, pulse `retire` during FETCH. Require no change to `pc` or `instret`.
